traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_phase_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Purpose  : Signal controller for NUM_PHASES mutually conflicting phases.
//            Cycles ALLRED -> GREEN -> YELLOW -> ALLRED. The next phase is
//            chosen round-robin by vehicle demand. Emergency preemption is
//            supported. All timing is derived from a one-second prescaler.
// Option   : `define TRAFFIC_PED_WALK_EN adds a pedestrian WALK interval,
//            which is entered from ALLRED when a request is pending. When
//            the macro is undefined, ped_req is ignored and walk is tied low.
// Ports    : clk          - system clock, rising-edge active
//            reset        - asynchronous active-low reset
//            sensor       - per-phase vehicle demand (level)
//            emerg        - emergency preemption request (level)
//            emerg_phase  - phase to serve while preempted
//            ped_req      - pedestrian request (pulse or level)
//            light        - 2-bit lamp code per phase: 00 red, 01 yellow, 10 green
//            active_phase - phase owning (or last owning) right-of-way
//            walk         - pedestrian walk lamp
//            sec_tick     - one-cycle pulse per elapsed second of a state
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 2,
    parameter int CLK_DIV    = 2080000,
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int WALK_SEC   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PHASES-1:0]         sensor,
    input  logic                          emerg,
    input  logic [$clog2(NUM_PHASES)-1:0] emerg_phase,
    input  logic                          ped_req,
    output logic [2*NUM_PHASES-1:0]       light,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          walk,
    output logic                          sec_tick
);

    localparam int c_PH_W    = $clog2(NUM_PHASES);
    localparam int c_PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_MAX_GY  = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
    localparam int c_MAX_AW  = (ALLRED_SEC > WALK_SEC) ? ALLRED_SEC : WALK_SEC;
    localparam int c_MAX_DUR = (c_MAX_GY > c_MAX_AW) ? c_MAX_GY : c_MAX_AW;
    localparam int c_SEC_W   = $clog2(c_MAX_DUR + 1);

    localparam logic [c_PRE_W-1:0]    c_PRE_LAST    = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_SEC_W-1:0]    c_GREEN_LAST  = c_SEC_W'(GREEN_SEC - 1);
    // Saturation marker: green minimum has elapsed and the phase is holding.
    localparam logic [c_SEC_W-1:0]    c_GREEN_HOLD  = c_SEC_W'(GREEN_SEC);
    localparam logic [c_SEC_W-1:0]    c_YELLOW_LAST = c_SEC_W'(YELLOW_SEC - 1);
    localparam logic [c_SEC_W-1:0]    c_ALLRED_LAST = c_SEC_W'(ALLRED_SEC - 1);
`ifdef TRAFFIC_PED_WALK_EN
    localparam logic [c_SEC_W-1:0]    c_WALK_LAST   = c_SEC_W'(WALK_SEC - 1);
`endif
    localparam logic [c_PH_W-1:0]     c_LAST_PHASE  = c_PH_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] c_PH_ONE      = NUM_PHASES'(1);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
`ifdef TRAFFIC_PED_WALK_EN
        ,
        ST_WALK   = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [c_PH_W-1:0]       active_q, active_d;
    logic [c_PRE_W-1:0]      presc_q, presc_d;
    logic [c_SEC_W-1:0]      sec_q, sec_d;
    logic [2*NUM_PHASES-1:0] light_q, light_d;
    logic                    tick_q, tick_d;

    logic [c_SEC_W-1:0]      w_dur_last;
    logic [c_PH_W-1:0]       w_rr_next;
    logic                    w_tick;
    logic                    w_done;
    logic                    w_green_elapsed;
    logic                    w_emerg_vld;
    logic                    w_other_dem;
    logic                    w_ped_pend;

`ifdef TRAFFIC_PED_WALK_EN
    logic                    pend_q, pend_d;
    logic                    walk_q, walk_d;

    assign w_ped_pend = pend_q | ped_req;
    assign walk       = walk_q;
`else
    logic                    w_unused_ped;

    assign w_unused_ped = ped_req;
    assign w_ped_pend   = 1'b0;
    assign walk         = 1'b0;
`endif

    assign light        = light_q;
    assign active_phase = active_q;
    assign sec_tick     = tick_q;

    // ------------------------------------------------------------------
    // Timer decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dur_last = c_ALLRED_LAST;
        case (state_q)
            ST_GREEN:  w_dur_last = c_GREEN_LAST;
            ST_YELLOW: w_dur_last = c_YELLOW_LAST;
`ifdef TRAFFIC_PED_WALK_EN
            ST_WALK:   w_dur_last = c_WALK_LAST;
`endif
            default:   w_dur_last = c_ALLRED_LAST;
        endcase
    end

    assign w_tick          = (presc_q == c_PRE_LAST);
    assign w_done          = w_tick && (sec_q == w_dur_last);
    assign w_green_elapsed = w_done || (sec_q == c_GREEN_HOLD);
    // An out-of-range emergency phase is treated as no request at all.
    assign w_emerg_vld     = emerg && (int'(emerg_phase) < NUM_PHASES);
    assign w_other_dem     = |(sensor & ~(c_PH_ONE << active_q));

    // ------------------------------------------------------------------
    // Round-robin search: first phase after active_q with demand. The
    // active phase itself is examined last. With no demand anywhere,
    // the next phase in sequence is taken.
    // ------------------------------------------------------------------
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        w_rr_next = (active_q == c_LAST_PHASE) ? '0 : active_q + 1'b1;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            idx = int'(active_q) + i;
            if (idx >= NUM_PHASES) begin
                idx = idx - NUM_PHASES;
            end
            if (!found && sensor[c_PH_W'(idx)]) begin
                found     = 1'b1;
                w_rr_next = c_PH_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        presc_d  = w_tick ? '0 : presc_q + 1'b1;
        sec_d    = w_tick ? sec_q + 1'b1 : sec_q;
`ifdef TRAFFIC_PED_WALK_EN
        pend_d   = pend_q | ped_req;
`endif
        case (state_q)
            ST_ALLRED: begin
                if (w_done) begin
                    if (w_emerg_vld) begin
                        // Preemption outranks a pending walk; the walk stays owed.
                        state_d  = ST_GREEN;
                        active_d = emerg_phase;
                    end
`ifdef TRAFFIC_PED_WALK_EN
                    else if (w_ped_pend) begin
                        state_d = ST_WALK;
                        pend_d  = 1'b0;
                    end
`endif
                    else begin
                        state_d  = ST_GREEN;
                        active_d = w_rr_next;
                    end
                end
            end
            ST_GREEN: begin
                // Once the minimum has run, park the second counter on the
                // hold marker so the exit can be taken on any later cycle.
                if (w_green_elapsed) begin
                    sec_d = c_GREEN_HOLD;
                end
                if (w_emerg_vld) begin
                    if (emerg_phase != active_q) begin
                        state_d = ST_YELLOW;
                    end
                end else if (w_green_elapsed && (w_other_dem || w_ped_pend)) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (w_done) begin
                    state_d = ST_ALLRED;
                end
            end
`ifdef TRAFFIC_PED_WALK_EN
            ST_WALK: begin
                // Requests arriving during the walk are served by it.
                pend_d = 1'b0;
                if (w_done) begin
                    state_d = ST_ALLRED;
                end
            end
`endif
            default: state_d = ST_ALLRED;
        endcase

        // Every state entry starts timing from zero.
        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so the lamps line
    // up with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        light_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (c_PH_W'(i) == active_d) begin
                if (state_d == ST_GREEN) begin
                    light_d[2*i +: 2] = 2'b10;
                end else if (state_d == ST_YELLOW) begin
                    light_d[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    assign tick_d = (presc_d == c_PRE_LAST);
`ifdef TRAFFIC_PED_WALK_EN
    assign walk_d = (state_d == ST_WALK);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ALLRED;
            active_q <= c_LAST_PHASE;
            presc_q  <= '0;
            sec_q    <= '0;
            light_q  <= '0;
            tick_q   <= 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
            pend_q   <= 1'b0;
            walk_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            light_q  <= light_d;
            tick_q   <= tick_d;
`ifdef TRAFFIC_PED_WALK_EN
            pend_q   <= pend_d;
            walk_q   <= walk_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Purpose  : Directed self-checking bench for traffic_phase_ctrl with
//            NUM_PHASES=3, CLK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2.
//            Cycle 0 is the first clock period after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sensor;
    logic         emerg;
    logic [1:0]   emerg_phase;
    logic         ped_req;
    logic [2*N-1:0] light;
    logic [1:0]   active_phase;
    logic         walk;
    logic         sec_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    traffic_phase_ctrl #(
        .NUM_PHASES (N),
        .CLK_DIV    (4),
        .GREEN_SEC  (3),
        .YELLOW_SEC (2),
        .ALLRED_SEC (1),
        .WALK_SEC   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .emerg        (emerg),
        .emerg_phase  (emerg_phase),
        .ped_req      (ped_req),
        .light        (light),
        .active_phase (active_phase),
        .walk         (walk),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    // At most one phase may show non-red, and code 11 never appears.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            int nonred;
            bit bad;
            nonred = 0;
            bad    = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (light[2*i +: 2] != 2'b00) nonred++;
                if (light[2*i +: 2] == 2'b11) bad = 1'b1;
            end
            checks++;
            if (nonred > 1 || bad) begin
                failures++;
                $display("FAIL exclusive light=%b nonred=%0d required<=1 and no 11", light, nonred);
            end
        end
    end

    task automatic start();
        reset = 1'b0; sensor = '0; emerg = 1'b0; emerg_phase = '0; ped_req = 1'b0;
        #2;
        @(posedge clk); #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sensor = '0; emerg = 1'b0; emerg_phase = '0; ped_req = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL reset_light got=%b exp=%b", light, 6'b000000); end
        checks++; if (active_phase !== 2'd2) begin failures++; $display("FAIL reset_active got=%0d exp=2", active_phase); end
        checks++; if (walk !== 1'b0) begin failures++; $display("FAIL reset_walk got=%b exp=0", walk); end
        checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", sec_tick); end
    endtask

    task automatic test_basic_cycle();
        start();
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL basic_c0 got=%b exp=%b", light, 6'b000000); end
        step_to(2);
        checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL basic_tick_c2 got=%b exp=0", sec_tick); end
        step_to(3);
        checks++; if (sec_tick !== 1'b1) begin failures++; $display("FAIL basic_tick_c3 got=%b exp=1", sec_tick); end
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL basic_c3 got=%b exp=%b", light, 6'b000000); end
        step_to(4);
        sensor = 3'b010;
        checks++; if (light !== 6'b000010 || active_phase !== 2'd0) begin failures++; $display("FAIL basic_p0_green_c4 got=%b/%0d exp=%b/0", light, active_phase, 6'b000010); end
        step_to(15);
        checks++; if (light !== 6'b000010) begin failures++; $display("FAIL basic_green_c15 got=%b exp=%b", light, 6'b000010); end
        step_to(16);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL basic_yellow_c16 got=%b exp=%b", light, 6'b000001); end
        step_to(23);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL basic_yellow_c23 got=%b exp=%b", light, 6'b000001); end
        step_to(24);
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL basic_red_c24 got=%b exp=%b", light, 6'b000000); end
        step_to(27);
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL basic_red_c27 got=%b exp=%b", light, 6'b000000); end
        step_to(28);
        checks++; if (light !== 6'b001000 || active_phase !== 2'd1) begin failures++; $display("FAIL basic_p1_green_c28 got=%b/%0d exp=%b/1", light, active_phase, 6'b001000); end
    endtask

    task automatic test_green_hold();
        start();
        step_to(4);
        checks++; if (light !== 6'b000010) begin failures++; $display("FAIL hold_green_c4 got=%b exp=%b", light, 6'b000010); end
        step_to(40);
        checks++; if (light !== 6'b000010) begin failures++; $display("FAIL hold_green_c40 got=%b exp=%b", light, 6'b000010); end
        sensor = 3'b100;
        step_to(41);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL hold_yellow_c41 got=%b exp=%b", light, 6'b000001); end
        step_to(52);
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL hold_red_c52 got=%b exp=%b", light, 6'b000000); end
        step_to(53);
        checks++; if (light !== 6'b100000 || active_phase !== 2'd2) begin failures++; $display("FAIL hold_p2_green_c53 got=%b/%0d exp=%b/2", light, active_phase, 6'b100000); end
    endtask

    task automatic test_emerg();
        start();
        step_to(4);
        emerg = 1'b1; emerg_phase = 2'd2;
        step_to(5);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL emerg_yellow_c5 got=%b exp=%b", light, 6'b000001); end
        step_to(12);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL emerg_yellow_c12 got=%b exp=%b", light, 6'b000001); end
        step_to(13);
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL emerg_red_c13 got=%b exp=%b", light, 6'b000000); end
        step_to(17);
        sensor = 3'b001;
        checks++; if (light !== 6'b100000 || active_phase !== 2'd2) begin failures++; $display("FAIL emerg_p2_green_c17 got=%b/%0d exp=%b/2", light, active_phase, 6'b100000); end
        step_to(40);
        checks++; if (light !== 6'b100000) begin failures++; $display("FAIL emerg_hold_c40 got=%b exp=%b", light, 6'b100000); end
        emerg = 1'b0;
        step_to(41);
        checks++; if (light !== 6'b010000) begin failures++; $display("FAIL emerg_release_c41 got=%b exp=%b", light, 6'b010000); end
    endtask

    task automatic test_emerg_invalid();
        start();
        emerg = 1'b1; emerg_phase = 2'd3;
        step_to(4);
        checks++; if (light !== 6'b000010 || active_phase !== 2'd0) begin failures++; $display("FAIL badphase_green_c4 got=%b/%0d exp=%b/0", light, active_phase, 6'b000010); end
        step_to(5);
        checks++; if (light !== 6'b000010) begin failures++; $display("FAIL badphase_green_c5 got=%b exp=%b", light, 6'b000010); end
        step_to(20);
        checks++; if (light !== 6'b000010) begin failures++; $display("FAIL badphase_green_c20 got=%b exp=%b", light, 6'b000010); end
        emerg = 1'b0;
    endtask

    task automatic test_ped();
        start();
        step_to(4);
        sensor = 3'b010;
        step_to(28);
        checks++; if (light !== 6'b001000 || active_phase !== 2'd1) begin failures++; $display("FAIL ped_p1_green_c28 got=%b/%0d exp=%b/1", light, active_phase, 6'b001000); end
        sensor = 3'b000;
        step_to(30);
        ped_req = 1'b1;
        step_to(31);
        ped_req = 1'b0;
        step_to(39);
        checks++; if (light !== 6'b001000) begin failures++; $display("FAIL ped_green_c39 got=%b exp=%b", light, 6'b001000); end
`ifdef TRAFFIC_PED_WALK_EN
        step_to(40);
        checks++; if (light !== 6'b000100) begin failures++; $display("FAIL ped_yellow_c40 got=%b exp=%b", light, 6'b000100); end
        step_to(51);
        checks++; if (light !== 6'b000000 || walk !== 1'b0) begin failures++; $display("FAIL ped_allred_c51 got=%b/%b exp=%b/0", light, walk, 6'b000000); end
        step_to(52);
        checks++; if (light !== 6'b000000 || walk !== 1'b1) begin failures++; $display("FAIL ped_walk_c52 got=%b/%b exp=%b/1", light, walk, 6'b000000); end
        step_to(59);
        checks++; if (walk !== 1'b1) begin failures++; $display("FAIL ped_walk_c59 got=%b exp=1", walk); end
        step_to(60);
        checks++; if (light !== 6'b000000 || walk !== 1'b0) begin failures++; $display("FAIL ped_allred_c60 got=%b/%b exp=%b/0", light, walk, 6'b000000); end
        step_to(64);
        checks++; if (light !== 6'b100000 || active_phase !== 2'd2) begin failures++; $display("FAIL ped_p2_green_c64 got=%b/%0d exp=%b/2", light, active_phase, 6'b100000); end
`else
        step_to(40);
        checks++; if (light !== 6'b001000) begin failures++; $display("FAIL ped_off_hold_c40 got=%b exp=%b", light, 6'b001000); end
        step_to(64);
        checks++; if (light !== 6'b001000 || walk !== 1'b0) begin failures++; $display("FAIL ped_off_hold_c64 got=%b/%b exp=%b/0", light, walk, 6'b001000); end
`endif
    endtask

    task automatic test_async_reset();
        start();
        step_to(4);
        sensor = 3'b010;
        step_to(18);
        checks++; if (light !== 6'b000001) begin failures++; $display("FAIL areset_yellow_c18 got=%b exp=%b", light, 6'b000001); end
        #2 reset = 1'b0;
        #1;
        checks++; if (light !== 6'b000000 || active_phase !== 2'd2) begin failures++; $display("FAIL areset_immediate got=%b/%0d exp=%b/2", light, active_phase, 6'b000000); end
        checks++; if (sec_tick !== 1'b0 || walk !== 1'b0) begin failures++; $display("FAIL areset_tick_walk got=%b/%b exp=0/0", sec_tick, walk); end
        sensor = 3'b000;
        @(posedge clk); #1;
        reset = 1'b1;
        cyc   = 0;
        step_to(1);
        checks++; if (light !== 6'b000000) begin failures++; $display("FAIL areset_allred_c1 got=%b exp=%b", light, 6'b000000); end
        step_to(4);
        checks++; if (light !== 6'b000010 || active_phase !== 2'd0) begin failures++; $display("FAIL areset_p0_green_c4 got=%b/%0d exp=%b/0", light, active_phase, 6'b000010); end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_basic_cycle();
        test_green_hold();
        test_emerg();
        test_emerg_invalid();
        test_ped();
        test_async_reset();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
